// File: rtl/dshot_frame_decoder.sv
// DShot receiver: decodes bits by high-pulse width, validates CRC, latches throttle/command.
// Optional DSHOT_STATS_EN adds saturating good/bad frame counters.
module dshot_frame_decoder #(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned DSHOT_RATE = 150000,
    parameter bit          INVERTED   = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_pin_i,
    output logic [10:0] throttle_o,
    output logic [5:0]  command_o,
    output logic        is_command_o,
    output logic        telemetry_req_o,
    output logic        frame_valid_o,
    output logic        frame_error_o,
    output logic [1:0]  error_code_o,
    output logic        busy_o
`ifdef DSHOT_STATS_EN
   ,output logic [15:0] good_count_o,
    output logic [15:0] bad_count_o
`endif
);

    localparam int unsigned BitCyc = CLK_HZ / DSHOT_RATE;
    localparam int unsigned MinHi  = BitCyc / 4;
    localparam int unsigned Thresh = BitCyc * 9 / 16;
    localparam int unsigned MaxHi  = BitCyc * 7 / 8;
    localparam int unsigned LowTo  = BitCyc;
    localparam int unsigned CntW   = $clog2(2 * BitCyc);

    localparam logic [CntW-1:0] MinHiC  = CntW'(MinHi);
    localparam logic [CntW-1:0] ThreshC = CntW'(Thresh);
    localparam logic [CntW-1:0] MaxHiC  = CntW'(MaxHi);
    localparam logic [CntW-1:0] LowToC  = CntW'(LowTo);

    localparam logic [1:0] ErrCrc     = 2'd1;
    localparam logic [1:0] ErrWidth   = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StHigh,
        StLow,
        StCheck,
        StResync
    } state_e;

    state_e          state_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            sig_prev_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [15:0]     shift_q;

    logic [10:0]     throttle_q;
    logic [5:0]      command_q;
    logic            is_command_q;
    logic            telemetry_q;
    logic            frame_valid_q;
    logic            frame_error_q;
    logic [1:0]      error_code_q;

    logic            sig;
    logic [CntW-1:0] cnt_inc;
    logic [10:0]     value;
    logic [3:0]      crc_exp;
    logic            crc_ok;
    logic            bit_val;

    always_comb begin
        sig     = sync2_q ^ INVERTED;
        cnt_inc = cnt_q + CntW'(1);
        value   = shift_q[15:5];
        crc_exp = shift_q[15:12] ^ shift_q[11:8] ^ shift_q[7:4];
        if (INVERTED) begin
            crc_exp = ~crc_exp;
        end
        crc_ok  = (crc_exp == shift_q[3:0]);
        bit_val = (cnt_q >= ThreshC);
    end

    // cnt_q holds the width of the current level including the edge-detect cycle,
    // so the thresholds compare directly against pulse widths in clock cycles.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            sync1_q       <= INVERTED;
            sync2_q       <= INVERTED;
            sig_prev_q    <= 1'b0;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            throttle_q    <= '0;
            command_q     <= '0;
            is_command_q  <= 1'b0;
            telemetry_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            error_code_q  <= '0;
        end else begin
            sync1_q       <= in_pin_i;
            sync2_q       <= sync1_q;
            sig_prev_q    <= sig;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (sig && !sig_prev_q) begin
                        state_q   <= StHigh;
                        cnt_q     <= CntW'(1);
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end

                StHigh: begin
                    if (sig) begin
                        if (cnt_inc > MaxHiC) begin
                            frame_error_q <= 1'b1;
                            error_code_q  <= ErrWidth;
                            state_q       <= StResync;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else if (cnt_q < MinHiC) begin
                        frame_error_q <= 1'b1;
                        error_code_q  <= ErrWidth;
                        state_q       <= StResync;
                        cnt_q         <= CntW'(1);
                    end else begin
                        shift_q   <= {shift_q[14:0], bit_val};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            state_q <= StCheck;
                        end else begin
                            state_q <= StLow;
                            cnt_q   <= CntW'(1);
                        end
                    end
                end

                StLow: begin
                    if (sig) begin
                        state_q <= StHigh;
                        cnt_q   <= CntW'(1);
                    end else if (cnt_inc >= LowToC) begin
                        frame_error_q <= 1'b1;
                        error_code_q  <= ErrTimeout;
                        state_q       <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                StCheck: begin
                    if (crc_ok) begin
                        frame_valid_q <= 1'b1;
                        telemetry_q   <= shift_q[4];
                        if (value < 11'd48) begin
                            is_command_q <= 1'b1;
                            command_q    <= value[5:0];
                            throttle_q   <= '0;
                        end else begin
                            is_command_q <= 1'b0;
                            throttle_q   <= value - 11'd48;
                        end
                    end else begin
                        frame_error_q <= 1'b1;
                        error_code_q  <= ErrCrc;
                    end
                    state_q <= StIdle;
                end

                StResync: begin
                    if (sig) begin
                        cnt_q <= '0;
                    end else if (cnt_inc >= LowToC) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign throttle_o      = throttle_q;
    assign command_o       = command_q;
    assign is_command_o    = is_command_q;
    assign telemetry_req_o = telemetry_q;
    assign frame_valid_o   = frame_valid_q;
    assign frame_error_o   = frame_error_q;
    assign error_code_o    = error_code_q;
    assign busy_o          = (state_q != StIdle);

`ifdef DSHOT_STATS_EN
    logic [15:0] good_count_q;
    logic [15:0] bad_count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            good_count_q <= '0;
            bad_count_q  <= '0;
        end else begin
            if (frame_valid_q && (good_count_q != 16'hFFFF)) begin
                good_count_q <= good_count_q + 16'd1;
            end
            if (frame_error_q && (bad_count_q != 16'hFFFF)) begin
                bad_count_q <= bad_count_q + 16'd1;
            end
        end
    end

    assign good_count_o = good_count_q;
    assign bad_count_o  = bad_count_q;
`endif

endmodule

// File: tb/tb_dshot_frame_decoder.sv
// Self-checking bench: one normal and one inverted decoder share a stimulus waveform
// and are compared against a frame-level reference model.
module tb_dshot_frame_decoder;

    logic clk = 1'b0;
    logic rst;
    logic level;
    logic pin_inv;

    always #5 clk = ~clk;
    assign pin_inv = ~level;

    logic [10:0] thr  [2];
    logic [5:0]  cmd  [2];
    logic        isc  [2];
    logic        tel  [2];
    logic        fv   [2];
    logic        fe   [2];
    logic [1:0]  code [2];
    logic        bsy  [2];
`ifdef DSHOT_STATS_EN
    logic [15:0] gc [2];
    logic [15:0] bc [2];
`endif

    dshot_frame_decoder #(.CLK_HZ(16000000), .DSHOT_RATE(150000), .INVERTED(1'b0)) dut0 (
        .clk_i          (clk),
        .reset_i        (rst),
        .in_pin_i       (level),
        .throttle_o     (thr[0]),
        .command_o      (cmd[0]),
        .is_command_o   (isc[0]),
        .telemetry_req_o(tel[0]),
        .frame_valid_o  (fv[0]),
        .frame_error_o  (fe[0]),
        .error_code_o   (code[0]),
        .busy_o         (bsy[0])
`ifdef DSHOT_STATS_EN
       ,.good_count_o   (gc[0]),
        .bad_count_o    (bc[0])
`endif
    );

    dshot_frame_decoder #(.CLK_HZ(16000000), .DSHOT_RATE(150000), .INVERTED(1'b1)) dut1 (
        .clk_i          (clk),
        .reset_i        (rst),
        .in_pin_i       (pin_inv),
        .throttle_o     (thr[1]),
        .command_o      (cmd[1]),
        .is_command_o   (isc[1]),
        .telemetry_req_o(tel[1]),
        .frame_valid_o  (fv[1]),
        .frame_error_o  (fe[1]),
        .error_code_o   (code[1]),
        .busy_o         (bsy[1])
`ifdef DSHOT_STATS_EN
       ,.good_count_o   (gc[1]),
        .bad_count_o    (bc[1])
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int e_thr [2] = '{0, 0};
    int e_cmd [2] = '{0, 0};
    int e_isc [2] = '{0, 0};
    int e_tel [2] = '{0, 0};
    int e_code[2] = '{0, 0};
    int e_good[2] = '{0, 0};
    int e_bad [2] = '{0, 0};
    int e_sv  [2] = '{0, 0};
    int e_se  [2] = '{0, 0};

    // Observed strobe counts
    int nv[2] = '{0, 0};
    int ne[2] = '{0, 0};
    int both_hi = 0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (fv[k]) nv[k]++;
                if (fe[k]) ne[k]++;
                if (fv[k] && fe[k]) both_hi++;
            end
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_crc(input int w, input bit inv);
        int x;
        int c;
        x = w / 16;
        c = (x ^ (x / 16) ^ (x / 256)) % 16;
        if (inv) c = 15 - c;
        return c;
    endfunction

    function automatic bit model_ok(input int w, input bit inv);
        return model_crc(w, inv) == (w % 16);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_thr[k] = 0; e_cmd[k] = 0; e_isc[k] = 0; e_tel[k] = 0;
            e_code[k] = 0; e_good[k] = 0; e_bad[k] = 0;
        end
    endtask

    task automatic model_error(input int k, input int c);
        e_code[k] = c;
        e_bad[k]++;
        e_se[k]++;
    endtask

    task automatic model_frame(input int k, input int w);
        int v;
        if (model_ok(w, k == 1)) begin
            v = w / 32;
            if (v < 48) begin
                e_isc[k] = 1;
                e_cmd[k] = v;
                e_thr[k] = 0;
            end else begin
                e_isc[k] = 0;
                e_thr[k] = v - 48;
            end
            e_tel[k] = (w / 16) % 2;
            e_good[k]++;
            e_sv[k]++;
        end else begin
            model_error(k, 1);
        end
    endtask

    task automatic check_outs(input int k, input string tag);
        check_eq($sformatf("%s.d%0d.throttle", tag, k), int'(thr[k]), e_thr[k]);
        check_eq($sformatf("%s.d%0d.command", tag, k), int'(cmd[k]), e_cmd[k]);
        check_eq($sformatf("%s.d%0d.is_command", tag, k), int'(isc[k]), e_isc[k]);
        check_eq($sformatf("%s.d%0d.telemetry", tag, k), int'(tel[k]), e_tel[k]);
        check_eq($sformatf("%s.d%0d.error_code", tag, k), int'(code[k]), e_code[k]);
        check_eq($sformatf("%s.d%0d.busy", tag, k), int'(bsy[k]), 0);
`ifdef DSHOT_STATS_EN
        check_eq($sformatf("%s.d%0d.good_count", tag, k), int'(gc[k]), e_good[k]);
        check_eq($sformatf("%s.d%0d.bad_count", tag, k), int'(bc[k]), e_bad[k]);
`endif
    endtask

    // mode 0: random legal widths; 1: width/gap extremes; 2: fixed 40/79 pulses, 106-cycle bits
    task automatic send_bits(input logic [15:0] w, input int nbits, input int mode);
        int hi;
        int lo;
        bit b;
        for (int i = 0; i < nbits; i++) begin
            b = w[15-i];
            if (mode == 0) begin
                hi = b ? int'($urandom_range(92, 59)) : int'($urandom_range(58, 26));
                lo = int'($urandom_range(60, 5));
            end else if (mode == 1) begin
                hi = b ? ((i % 2) ? 59 : 92) : ((i % 2) ? 26 : 58);
                lo = (i % 2) ? 105 : 1;
            end else begin
                hi = b ? 79 : 40;
                lo = 106 - hi;
            end
            level = 1'b1;
            repeat (hi) tick();
            level = 1'b0;
            if (i < nbits - 1) repeat (lo) tick();
        end
    endtask

    // Called right after the final falling edge; checks exact strobe timing and outputs.
    task automatic expect_frame(input logic [15:0] w, input string tag);
        bit ok[2];
        for (int k = 0; k < 2; k++) ok[k] = model_ok(int'(w), k == 1);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("%s.d%0d.early_strobe", tag, k), int'(fv[k] | fe[k]), 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s.d%0d.frame_valid", tag, k), int'(fv[k]), int'(ok[k]));
            check_eq($sformatf("%s.d%0d.frame_error", tag, k), int'(fe[k]), int'(!ok[k]));
            model_frame(k, int'(w));
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s.d%0d.strobe_width", tag, k), int'(fv[k] | fe[k]), 0);
            check_outs(k, tag);
        end
    endtask

    task automatic expect_line_error(input int c, input string tag, input int bv0, input int be0,
                                     input int bv1, input int be1);
        int bv[2];
        int be[2];
        bv[0] = bv0; be[0] = be0; bv[1] = bv1; be[1] = be1;
        for (int k = 0; k < 2; k++) begin
            model_error(k, c);
            check_eq($sformatf("%s.d%0d.errors", tag, k), ne[k] - be[k], 1);
            check_eq($sformatf("%s.d%0d.valids", tag, k), nv[k] - bv[k], 0);
            check_outs(k, tag);
        end
    endtask

    initial begin
        logic [15:0] w;
        int x;
        int c;
        rst = 1'b1;
        level = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outs(k, "reset");
        rst = 1'b0;
        repeat (5) tick();

        send_bits(16'h82C6, 16, 2);
        expect_frame(16'h82C6, "f82c6");
        check_eq("f82c6.const_throttle", int'(thr[0]), 998);
        repeat (10) tick();

        send_bits(16'h0011, 16, 2);
        expect_frame(16'h0011, "f0011");
        check_eq("f0011.const_is_command", int'(isc[0]), 1);
        repeat (10) tick();

        send_bits(16'h82C7, 16, 2);
        expect_frame(16'h82C7, "f82c7");
        check_eq("f82c7.const_error_code", int'(code[0]), 1);
        repeat (10) tick();

        send_bits(16'h82C9, 16, 2);
        expect_frame(16'h82C9, "f82c9");
        check_eq("f82c9.inv_throttle", int'(thr[1]), 998);
        repeat (10) tick();

        send_bits(16'h82C6, 16, 1);
        expect_frame(16'h82C6, "extremes");
        repeat (10) tick();

        begin : timeout_case
            int v0, e0, v1, e1;
            v0 = nv[0]; e0 = ne[0]; v1 = nv[1]; e1 = ne[1];
            send_bits(16'h82C6, 10, 0);
            repeat (120) tick();
            @(negedge clk);
            expect_line_error(3, "timeout", v0, e0, v1, e1);
        end

        begin : overlong_case
            int v0, e0, v1, e1;
            v0 = nv[0]; e0 = ne[0]; v1 = nv[1]; e1 = ne[1];
            level = 1'b1;
            repeat (93) tick();
            level = 1'b0;
            repeat (50) tick();
            send_bits(16'h82C6, 16, 0);
            repeat (120) tick();
            @(negedge clk);
            expect_line_error(2, "overlong", v0, e0, v1, e1);
        end
        tick();
        send_bits(16'h82C6, 16, 0);
        expect_frame(16'h82C6, "after_resync");
        repeat (5) tick();

        begin : short_case
            int v0, e0, v1, e1;
            v0 = nv[0]; e0 = ne[0]; v1 = nv[1]; e1 = ne[1];
            level = 1'b1;
            repeat (20) tick();
            level = 1'b0;
            repeat (120) tick();
            @(negedge clk);
            expect_line_error(2, "short", v0, e0, v1, e1);
        end
        tick();

        for (int n = 0; n < 28; n++) begin
            x = ($urandom_range(3, 0) == 0) ? int'($urandom_range(127, 0))
                                            : int'($urandom_range(4095, 0));
            c = model_crc(x * 16, $urandom_range(1, 0) == 1);
            if ($urandom_range(4, 0) == 0) c = (c + int'($urandom_range(15, 1))) % 16;
            w = 16'(x * 16 + c);
            send_bits(w, 16, 0);
            expect_frame(w, $sformatf("rand%0d", n));
            repeat ($urandom_range(30, 2)) tick();
        end

        send_bits(16'h82C6, 8, 0);
        rst = 1'b1;
        repeat (2) tick();
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outs(k, "midreset");
        rst = 1'b0;
        repeat (5) tick();
        send_bits(16'h82C6, 16, 2);
        expect_frame(16'h82C6, "post_reset");

        repeat (5) tick();
        check_eq("never_both", both_hi, 0);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("total.d%0d.valids", k), nv[k], e_sv[k]);
            check_eq($sformatf("total.d%0d.errors", k), ne[k], e_se[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dshot_frame_decoder.md
Name: dshot_frame_decoder

Overview:
Parametrised DShot receiver. It decodes each bit by measuring its high-pulse width, not by sampling at mid-bit. The bit period is derived from CLK_HZ and DSHOT_RATE, so it supports DShot150/300/600 and inverted (bidirectional) DShot. Decoded throttle and command values are held in registers, with one-cycle valid and error strobes. It sits between the ESC input pin and the motor-drive/command logic.

Parameters:
CLK_HZ, 16000000, system clock frequency in Hz.
DSHOT_RATE, 150000, bit rate in bit/s.
INVERTED, 0, 1 = idle-high line and inverted CRC (bidirectional DShot).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
in_pin  input  1  asynchronous DShot line.
throttle  output  11  last good throttle (value-48), 0..1999.
command  output  6  last good command value (valid when is_command=1).
is_command  output  1  last good frame value < 48.
telemetry_req  output  1  telemetry bit of last good frame.
frame_valid  output  1  one-cycle strobe: good frame latched.
frame_error  output  1  one-cycle strobe: frame rejected.
error_code  output  2  1=CRC, 2=pulse width, 3=timeout; held until next strobe.
busy  output  1  high while not in IDLE.

Behaviour:
- Input path: in_pin passes through a 2-flop synchronizer, then is XORed with INVERTED to give active-high "sig".
- Derived constants (integer math):
  - BIT_CYC = CLK_HZ/DSHOT_RATE (106 at defaults).
  - MIN_HI = BIT_CYC/4 (26).
  - THRESH = BIT_CYC*9/16 (59).
  - MAX_HI = BIT_CYC*7/8 (92).
  - LOW_TO = BIT_CYC (106).
  - Counter width = $clog2(2*BIT_CYC).
- States: IDLE, HIGH, LOW, CHECK, RESYNC.
- IDLE: on sig rising (sig=1, previous 0) → HIGH; clear the high counter, the bit count and the shift register.
- HIGH: count cycles while sig=1.
  - Count > MAX_HI → error 2, go to RESYNC.
  - On sig falling: count < MIN_HI → error 2, go to RESYNC.
  - Otherwise shift in bit (count ≥ THRESH ? 1 : 0), MSB first, and increment the bit count.
  - After the 16th bit → CHECK; else → LOW with the low counter cleared.
- LOW: count cycles while sig=0.
  - sig rising → HIGH.
  - Count reaches LOW_TO → error 3, go to IDLE.
- CHECK (exactly one cycle): value = d[15:5], t = d[4], crc = d[3:0].
  - Expected CRC = (d[15:4] ^ d[15:4]>>4 ^ d[15:4]>>8)[3:0], bitwise inverted when INVERTED=1.
  - Match: next cycle frame_valid=1 and latch outputs.
    - value < 48: is_command=1, command=value[5:0], throttle=0.
    - value ≥ 48: is_command=0, throttle=value-48, command unchanged.
    - telemetry_req = t.
  - Mismatch: error 1. Outputs hold previous values.
  - Either way → IDLE.
- RESYNC: wait until sig=0 for LOW_TO consecutive cycles, then → IDLE. Any sig=1 restarts the wait.
- Error strobes:
  - frame_error pulses one cycle, the cycle after detection.
  - error_code updates in the same cycle as the pulse.
  - frame_valid and frame_error are never high together.
- Latency: frame_valid is high 2 clk after the cycle the synchronized falling edge of bit 15 is seen (4 clk after the pin edge).
- Reset (any state, mid-frame included): state=IDLE, partial frame discarded.
  - All outputs 0: throttle=0, command=0, is_command=0, telemetry_req=0, frame_valid=0, frame_error=0, error_code=0, busy=0.
- A rising edge while in CHECK is ignored. The next frame needs a fresh rising edge from IDLE.

Optional Feature:
DSHOT_STATS_EN
- Defined: adds outputs good_count[15:0] and bad_count[15:0].
  - Increment on frame_valid / frame_error respectively.
  - Saturate at 0xFFFF; cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults; send frame 0x82C6 (value 1046, t=0, crc 6) with 40-cycle 0-pulses and 79-cycle 1-pulses → frame_valid one cycle, throttle=998, is_command=0, telemetry_req=0.
- Send 0x0011 → frame_valid; is_command=1, command=0, telemetry_req=1, throttle=0.
- Send 0x82C7 → frame_error, error_code=1; throttle still 998; no frame_valid.
- INVERTED=1, idle-high line, send 0x82C9 → frame_valid, throttle=998. Sending 0x82C6 → error_code=1.
- Stop after 10 bits, hold line low 106 cycles → frame_error, error_code=3, busy=0. Hold high 93 cycles → error_code=2; no decode until line low 106 cycles; then 0x82C6 decodes.
- Assert reset at bit 8, then send 0x82C6 → all outputs 0 after reset; the next frame decodes correctly. With DSHOT_STATS_EN: good_count=1, bad_count=0.
